// File: rtl/avmm_sample_writer.sv
// Round/saturate FIR samples to 32 bits, buffer them in a FIFO and write them
// as single-word Avalon-MM writes into a circular buffer.
module avmm_sample_writer #(
  parameter int          W_IN       = 57,
  parameter int          SHIFT      = 0,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          BUF_WORDS  = 1024
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [W_IN-1:0]               in_data,
  input  logic                          in_valid,
  input  logic                          enable,
  output logic [31:0]                   avm_address,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  output logic [3:0]                    avm_byteenable,
  input  logic                          avm_waitrequest,
  output logic                          wrap_pulse,
  output logic [15:0]                   overflow_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(BUF_WORDS);
  localparam int RW = (W_IN + 1 > 33) ? W_IN + 1 : 33;

  localparam logic signed [W_IN:0] RND    = ((W_IN+1)'(1) << SHIFT) >> 1;
  localparam logic signed [RW-1:0] SAT_HI = RW'(33'h0_7FFF_FFFF);
  localparam logic signed [RW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  // ---------------- stage 1: rounding and saturation ----------------
  logic signed [W_IN:0]  ext, rnd_sum, shifted;
  logic signed [RW-1:0]  r_ext;
  logic [31:0]           sat;
  logic [31:0]           cond_q;
  logic                  cond_valid_q;

  always_comb begin
    ext     = {in_data[W_IN-1], in_data};
    rnd_sum = ext + RND;
    shifted = rnd_sum >>> SHIFT;
    r_ext   = RW'(shifted);
    if (r_ext > SAT_HI)      sat = 32'h7FFF_FFFF;
    else if (r_ext < SAT_LO) sat = 32'h8000_0000;
    else                     sat = r_ext[31:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cond_q       <= '0;
      cond_valid_q <= 1'b0;
    end else begin
      cond_valid_q <= in_valid && enable;
      if (in_valid && enable) cond_q <= sat;
    end
  end

  // ---------------- stage 2: FIFO ----------------
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q, level;
  logic        full, empty, push, pop, drop;
  logic [15:0] ovf_q;

  assign level = wptr_q - rptr_q;
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (level == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign push  = cond_valid_q && (!full || pop);
  assign drop  = cond_valid_q && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= cond_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
      if (drop && ovf_q != '1) ovf_q <= ovf_q + 16'd1;
    end
  end

  // ---------------- writer FSM ----------------
  state_t        state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [31:0]   addr_q, addr_d, data_q, data_d;
  logic          write_q, write_d, wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    wrap_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        write_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rptr_q[AW-1:0]];
          addr_d  = BASE_ADDR + (32'(index_q) << 2);
          write_d = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          index_d = index_q + IW'(1);
          wrap_d  = (index_q == IW'(BUF_WORDS - 1));
          if (!empty) begin
            pop    = 1'b1;
            data_d = mem_q[rptr_q[AW-1:0]];
            addr_d = BASE_ADDR + (32'(index_d) << 2);
          end else begin
            write_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        write_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      index_q <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      write_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      wrap_q  <= wrap_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = 4'hF;
  assign wrap_pulse     = wrap_q;
  assign overflow_count = ovf_q;
  assign fifo_level     = level;
  assign busy           = !empty || write_q;

endmodule

// File: doc/avmm_sample_writer.md
# avmm_sample_writer

Downstream stage of the symmetric FIR filter. Takes the filter's full-width output samples (no backpressure, one per valid cycle), rounds and saturates them to 32 bits, buffers them in a small FIFO, and writes them as single-word Avalon-MM master writes into a circular buffer in memory. Completes the AXI-Stream → FIR → Avalon-MM datapath.

## Interface
- W_IN, 57, signed input sample width; equals the FIR output width.
- SHIFT, 0, arithmetic right shift with round-half-up, applied before saturation; 0 ≤ SHIFT < W_IN.
- FIFO_DEPTH, 16, FIFO entries; power of 2, ≥ 2.
- BASE_ADDR, 32'h0000_0000, byte address of buffer word 0; 4-byte aligned.
- BUF_WORDS, 1024, circular buffer length in 32-bit words; power of 2, ≥ 2.
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_data  in  W_IN  signed sample from the FIR.
- in_valid  in  1  in_data valid this cycle; there is no ready signal.
- enable  in  1  capture enable; when 0, incoming samples are ignored.
- avm_address  out  32  byte address, BASE_ADDR + 4·index.
- avm_write  out  1  write request.
- avm_writedata  out  32  conditioned sample.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall.
- wrap_pulse  out  1  one-cycle pulse after the write to word BUF_WORDS-1 is accepted.
- overflow_count  out  16  dropped-sample count; saturates at 16'hFFFF.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  high while the FIFO is non-empty or avm_write is high.

## Operation
- Conditioning register (stage 1): loads when in_valid && enable.
  - Computes r = (in_data + (SHIFT ? 2^(SHIFT-1) : 0)) >>> SHIFT in W_IN+1 bits, so the add cannot overflow.
  - Saturates: r > 2^31-1 → 32'h7FFF_FFFF; r < -2^31 → 32'h8000_0000; otherwise r[31:0].
  - cond_valid is high for one cycle per loaded sample.
- FIFO (stage 2): pushes when cond_valid.
  - Push while full with no pop in the same cycle: the sample is dropped and overflow_count increments.
  - Push while full with a pop in the same cycle: the push is accepted.
  - Simultaneous push and pop leaves fifo_level unchanged.
- Writer FSM, two states:
  - IDLE: avm_write=0. If the FIFO is non-empty, pop the head into avm_writedata, drive avm_address from index, set avm_write=1, go to WRITE.
  - WRITE: hold avm_address, avm_writedata and avm_write stable while avm_waitrequest=1.
  - On avm_waitrequest=0 the write is accepted. index ← (index+1) mod BUF_WORDS. If the accepted index was BUF_WORDS-1, assert wrap_pulse in the next cycle.
  - After acceptance: if the FIFO is non-empty, load the next head in the same edge and stay in WRITE (back-to-back). Otherwise clear avm_write and go to IDLE.
  - Any other state encoding returns to IDLE.
- enable deassertion stops only new captures. The FIFO drains and index is preserved. Only resetn resets index.

## Timing
- Reset (resetn sampled low) sets:
  - avm_write=0, avm_address=BASE_ADDR, avm_writedata=0, avm_byteenable=4'hF
  - wrap_pulse=0, overflow_count=0, fifo_level=0, busy=0
  - index=0, state IDLE, FIFO empty, cond_valid=0
- Reset mid-transaction abandons the pending write; avm_write is low in the cycle after the reset edge.
- Latency: sample valid in cycle c, with the FIFO empty and the FSM in IDLE → avm_write first high in cycle c+3 carrying that sample.
- Throughput: one write per cycle while avm_waitrequest=0 and the FIFO is non-empty. There is no idle bubble between back-to-back writes.
- wrap_pulse is exactly one cycle wide, in the cycle after the accepting edge.
- overflow_count holds at 16'hFFFF once saturated.

## Test plan
- Reset: hold resetn low 2 cycles with random inputs → all outputs at their reset values, and avm_write stays 0 until a sample arrives.
- Single sample, SHIFT=0, in_data=5 in cycle c, waitrequest=0 → avm_write high in cycle c+3 only, writedata 32'h0000_0005, address BASE_ADDR, then IDLE.
- Rounding and saturation:
  - SHIFT=0: in_data=2^40 → 32'h7FFF_FFFF; in_data=-2^40 → 32'h8000_0000.
  - SHIFT=4: in_data=24 → 2; in_data=-24 → 32'hFFFF_FFFF (-1).
- Wait-state hold: avm_waitrequest high for 5 cycles → address, data and write stable for 6 cycles; accepted on the 6th; index advances by 1.
- Overflow: FIFO_DEPTH=16, waitrequest held high, 20 consecutive samples → fifo_level=16, overflow_count=3. On release, 17 writes occur in order with values 1..17.
- Wrap: BUF_WORDS=4, 5 samples, waitrequest=0 → addresses BASE, +4, +8, +12, BASE back-to-back; a single wrap_pulse in the cycle after the 4th write is accepted.
